// File: rtl/hazard_pkg.sv
// Shared definitions for the decode-stage hazard controller: forward selects,
// controller states and the shadow scoreboard entry layout.
package hazard_pkg;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_ALU = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_BUSY = 2'd1,
    FLUSH   = 2'd2
  } hz_state_e;

  // Destination part of a shadow entry; all a consumer needs to detect a match.
  typedef struct packed {
    logic       valid;
    logic [4:0] wr_addr;
    logic       reg_write;
  } dest_t;

  typedef struct packed {
    dest_t dst;
    logic  is_load;
  } shadow_t;

  localparam dest_t   DEST_NONE   = '0;
  localparam shadow_t SHADOW_NONE = '0;

  function automatic logic dest_hit(input dest_t d, input logic [4:0] addr);
    return d.valid & d.reg_write & (d.wr_addr == addr);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forward/stall resolver: youngest producer wins, r0 never forwards.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic       use_op,
  input  logic [4:0] addr,
  input  dest_t      ex_d,
  input  shadow_t    mem_e,
  input  dest_t      wb_d,
  output logic [1:0] sel,
  output logic       stall
);

  // Priority resolve against EX, then MEM, then WB.
  always_comb begin
    sel   = FWD_REG;
    stall = 1'b0;
    if (!use_op || (addr == 5'd0)) begin
      sel   = FWD_REG;
      stall = 1'b0;
    end else if (dest_hit(ex_d, addr)) begin
      sel   = FWD_REG;
      stall = 1'b1;
    end else if (dest_hit(mem_e.dst, addr)) begin
      sel   = mem_e.is_load ? FWD_MEM : FWD_ALU;
      stall = 1'b0;
    end else if (dest_hit(wb_d, addr)) begin
      sel   = FWD_WB;
      stall = 1'b0;
    end else begin
      sel   = FWD_REG;
      stall = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: shadow scoreboard of EX/MEM/WB destinations,
// forwarding selects, dependency stalls, multicycle-EX holds and flush sequencing.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MC_LAT    = 4,
  parameter int FLUSH_CYC = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_use_rs,
  input  logic       i_id_use_rt,
  input  logic [4:0] i_id_wr_addr,
  input  logic       i_id_reg_write,
  input  logic       i_id_is_load,
  input  logic       i_id_multicycle,
  input  logic       i_exception,
  input  logic       i_eret,
  output logic [1:0] o_mux_ctrl1,
  output logic [1:0] o_mux_ctrl2,
  output logic       o_stall_if,
  output logic       o_stall_id,
  output logic       o_bubble_ex,
  output logic       o_hold_ex,
  output logic       o_flush,
  output logic       o_busy
);

  localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 1);
  localparam logic [2:0] FL_LOAD = 3'(FLUSH_CYC);

  hz_state_e  state_r, state_nxt_s;
  logic [3:0] mc_cnt_r, mc_cnt_nxt_s;
  logic [2:0] fl_cnt_r, fl_cnt_nxt_s;
  shadow_t    ex_r, mem_r, id_entry_s;
  dest_t      wb_r;
  logic [1:0] sel1_s, sel2_s;
  logic       dep1_s, dep2_s, dep_s;
  logic       flush_start_s, advance_s, mc_start_s;

  fwd_sel u_fwd_rs (
    .use_op(i_id_use_rs), .addr(i_id_rs), .ex_d(ex_r.dst), .mem_e(mem_r),
    .wb_d(wb_r), .sel(sel1_s), .stall(dep1_s)
  );

  fwd_sel u_fwd_rt (
    .use_op(i_id_use_rt), .addr(i_id_rt), .ex_d(ex_r.dst), .mem_e(mem_r),
    .wb_d(wb_r), .sel(sel2_s), .stall(dep2_s)
  );

  // Pipeline events; an eret already in FLUSH is ignored, an exception always restarts it.
  always_comb begin
    dep_s         = dep1_s | dep2_s;
    flush_start_s = i_exception | (i_eret & i_id_valid & (state_r != FLUSH));
    advance_s     = i_id_valid & (state_r == RUN) & ~dep_s & ~flush_start_s;
    mc_start_s    = advance_s & i_id_multicycle;
    id_entry_s    = '{dst: '{valid: 1'b1, wr_addr: i_id_wr_addr, reg_write: i_id_reg_write},
                      is_load: i_id_is_load};
  end

  // State and counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r  <= RUN;
      mc_cnt_r <= 4'd0;
      fl_cnt_r <= 3'd0;
    end else begin
      state_r  <= state_nxt_s;
      mc_cnt_r <= mc_cnt_nxt_s;
      fl_cnt_r <= fl_cnt_nxt_s;
    end
  end

  // Next-state and counter update; a flush start pre-empts every state.
  always_comb begin
    state_nxt_s  = state_r;
    mc_cnt_nxt_s = mc_cnt_r;
    fl_cnt_nxt_s = fl_cnt_r;
    if (flush_start_s) begin
      state_nxt_s  = FLUSH;
      mc_cnt_nxt_s = 4'd0;
      fl_cnt_nxt_s = FL_LOAD;
    end else begin
      case (state_r)
        RUN: begin
          if (mc_start_s) begin
            state_nxt_s  = MC_BUSY;
            mc_cnt_nxt_s = MC_LOAD;
          end else begin
            state_nxt_s  = RUN;
          end
        end
        MC_BUSY: begin
          mc_cnt_nxt_s = (mc_cnt_r == 4'd0) ? 4'd0 : (mc_cnt_r - 4'd1);
          state_nxt_s  = (mc_cnt_r <= 4'd1) ? RUN : MC_BUSY;
        end
        FLUSH: begin
          fl_cnt_nxt_s = (fl_cnt_r == 3'd0) ? 3'd0 : (fl_cnt_r - 3'd1);
          state_nxt_s  = (fl_cnt_r <= 3'd1) ? RUN : FLUSH;
        end
        default: begin
          state_nxt_s  = RUN;
          mc_cnt_nxt_s = 4'd0;
          fl_cnt_nxt_s = 3'd0;
        end
      endcase
    end
  end

  // Shadow scoreboard advance; EX parks a multicycle op and is emptied on any flush.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ex_r  <= SHADOW_NONE;
      mem_r <= SHADOW_NONE;
      wb_r  <= DEST_NONE;
    end else begin
      wb_r  <= mem_r.dst;
      mem_r <= (state_r == MC_BUSY) ? SHADOW_NONE : ex_r;
      if (flush_start_s || (state_r == FLUSH)) begin
        ex_r <= SHADOW_NONE;
      end else if (state_r == MC_BUSY) begin
        ex_r <= ex_r;
      end else if (advance_s) begin
        ex_r <= id_entry_s;
      end else begin
        ex_r <= SHADOW_NONE;
      end
    end
  end

  // Output decode; everything is forced low while reset is applied.
  always_comb begin
    o_mux_ctrl1 = FWD_REG;
    o_mux_ctrl2 = FWD_REG;
    o_stall_if  = 1'b0;
    o_stall_id  = 1'b0;
    o_bubble_ex = 1'b0;
    o_hold_ex   = 1'b0;
    o_flush     = 1'b0;
    o_busy      = 1'b0;
    if (i_rst) begin
      o_busy = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          o_mux_ctrl1 = sel1_s;
          o_mux_ctrl2 = sel2_s;
          if (dep_s && !flush_start_s) begin
            o_stall_if  = 1'b1;
            o_stall_id  = 1'b1;
            o_bubble_ex = 1'b1;
          end else begin
            o_bubble_ex = 1'b0;
          end
        end
        MC_BUSY: begin
          o_mux_ctrl1 = sel1_s;
          o_mux_ctrl2 = sel2_s;
          o_busy      = 1'b1;
          if (!flush_start_s) begin
            o_stall_if = 1'b1;
            o_stall_id = 1'b1;
            o_hold_ex  = 1'b1;
          end else begin
            o_hold_ex  = 1'b0;
          end
        end
        FLUSH: begin
          o_flush = 1'b1;
          o_busy  = 1'b1;
        end
        default: begin
          o_busy = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a cycle-by-cycle vector table followed by
// hand-written multicycle, exception, eret and reset sequences.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst, id_valid, use_rs, use_rt, reg_write, is_load, multicycle, exc, eret;
  logic [4:0] rs, rt, wr_addr;
  logic [1:0] mux1, mux2;
  logic       stall_if, stall_id, bubble_ex, hold_ex, flush, busy;

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(.MC_LAT(4), .FLUSH_CYC(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_rs(rs), .i_id_rt(rt),
    .i_id_use_rs(use_rs), .i_id_use_rt(use_rt), .i_id_wr_addr(wr_addr),
    .i_id_reg_write(reg_write), .i_id_is_load(is_load), .i_id_multicycle(multicycle),
    .i_exception(exc), .i_eret(eret), .o_mux_ctrl1(mux1), .o_mux_ctrl2(mux2),
    .o_stall_if(stall_if), .o_stall_id(stall_id), .o_bubble_ex(bubble_ex),
    .o_hold_ex(hold_ex), .o_flush(flush), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs packed as {mux1, mux2, stall_if, stall_id, bubble, hold, flush, busy}.
  function automatic logic [9:0] pk(input logic [1:0] m1, input logic [1:0] m2, input logic st,
                                    input logic bub, input logic hold, input logic fl,
                                    input logic bsy);
    return {m1, m2, st, st, bub, hold, fl, bsy};
  endfunction

  typedef struct {
    logic       rst, v;
    logic [4:0] rs;
    logic       urs;
    logic [4:0] rt;
    logic       urt;
    logic [4:0] wa;
    logic       rw, ld, mc, exc, er;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(input logic r, input logic v, input logic [4:0] a_rs,
                              input logic a_urs, input logic [4:0] a_rt, input logic a_urt,
                              input logic [4:0] a_wa, input logic a_rw, input logic a_ld,
                              input logic a_mc, input logic a_exc, input logic a_er,
                              input logic [9:0] e);
    vec_t t;
    t.rst = r; t.v = v; t.rs = a_rs; t.urs = a_urs; t.rt = a_rt; t.urt = a_urt;
    t.wa = a_wa; t.rw = a_rw; t.ld = a_ld; t.mc = a_mc; t.exc = a_exc; t.er = a_er;
    t.exp = e;
    return t;
  endfunction

  // Apply one cycle of inputs just after the falling edge, then let them settle.
  task automatic drive(input logic r, input logic v, input logic [4:0] a_rs, input logic a_urs,
                       input logic [4:0] a_rt, input logic a_urt, input logic [4:0] a_wa,
                       input logic a_rw, input logic a_ld, input logic a_mc,
                       input logic a_exc, input logic a_er);
    @(negedge clk);
    rst = r; id_valid = v; rs = a_rs; use_rs = a_urs; rt = a_rt; use_rt = a_urt;
    wr_addr = a_wa; reg_write = a_rw; is_load = a_ld; multicycle = a_mc;
    exc = a_exc; eret = a_er;
    #1;
  endtask

  task automatic chk(input string nm, input logic [9:0] exp);
    logic [9:0] act;
    act = {mux1, mux2, stall_if, stall_id, bubble_ex, hold_ex, flush, busy};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b  {m1,m2,sif,sid,bub,hold,flush,busy}", nm, act, exp);
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic indep();
    drive(1'b0, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic div12();
    drive(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic read12();
    drive(1'b0, 1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; rs = 5'd0; rt = 5'd0; use_rs = 1'b0; use_rt = 1'b0;
    wr_addr = 5'd0; reg_write = 1'b0; is_load = 1'b0; multicycle = 1'b0;
    exc = 1'b0; eret = 1'b0;

    //            rst   v     rs     urs   rt     urt   wa      rw    ld    mc    exc   eret
    tbl[0]  = mk(1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[1]  = mk(1'b1, 1'b1, 5'd3,  1'b1, 5'd3,  1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[2]  = mk(1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    // add r3, then a reader of r3: stall, then ALU forward, then WB forward
    tbl[3]  = mk(1'b0, 1'b1, 5'd1,  1'b1, 5'd2,  1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[4]  = mk(1'b0, 1'b1, 5'd3,  1'b1, 5'd4,  1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pk(2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl[5]  = mk(1'b0, 1'b1, 5'd3,  1'b1, 5'd4,  1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pk(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[6]  = mk(1'b0, 1'b1, 5'd3,  1'b1, 5'd8,  1'b1, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pk(2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    // lw r5, then a reader of r5 on rt (and r0 on rs)
    tbl[7]  = mk(1'b0, 1'b1, 5'd2,  1'b1, 5'd0,  1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[8]  = mk(1'b0, 1'b1, 5'd0,  1'b1, 5'd5,  1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pk(2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl[9]  = mk(1'b0, 1'b1, 5'd0,  1'b1, 5'd5,  1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pk(2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[10] = mk(1'b0, 1'b1, 5'd5,  1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pk(2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    // r0 writer in EX never stalls; an unused operand never forwards
    tbl[11] = mk(1'b0, 1'b1, 5'd10, 1'b0, 5'd0,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[12] = mk(1'b0, 1'b1, 5'd10, 1'b1, 5'd10, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pk(2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].rs, tbl[i].urs, tbl[i].rt, tbl[i].urt,
            tbl[i].wa, tbl[i].rw, tbl[i].ld, tbl[i].mc, tbl[i].exc, tbl[i].er);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Multicycle div: three hold cycles, then an independent op flows, then ALU forward of r12
    div12();
    chk("mc_issue", pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 1; k <= 3; k++) begin
      indep();
      chk($sformatf("mc_hold%0d", k), pk(2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    end
    indep();
    chk("mc_release", pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    read12();
    chk("mc_result_fwd", pk(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Exception in the second hold cycle aborts the div
    div12();
    chk("ex_issue", pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    indep();
    chk("ex_hold1", pk(2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    drive(1'b0, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ex_pulse", pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    read12();
    chk("ex_flush1", pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    read12();
    chk("ex_flush2", pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    read12();
    chk("ex_shadow_clear", pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // eret alone, then eret together with an exception
    for (int p = 0; p < 2; p++) begin
      drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, p[0], 1'b1);
      chk($sformatf("eret%0d_start", p), pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      idle();
      chk($sformatf("eret%0d_flush1", p), pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      idle();
      chk($sformatf("eret%0d_flush2", p), pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      idle();
      chk($sformatf("eret%0d_done", p), pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end

    // eret without a valid ID instruction is ignored
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("eret_invalid", pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    idle();
    chk("eret_invalid_next", pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Exception during FLUSH reloads the flush counter
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("reload_start", pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("reload_flush1", pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    idle();
    chk("reload_flush2", pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    idle();
    chk("reload_flush3", pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    idle();
    chk("reload_done", pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Reset in the middle of a multicycle hold
    div12();
    chk("rst_mc_issue", pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    indep();
    chk("rst_mc_hold", pk(2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    drive(1'b1, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_op", pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    read12();
    chk("rst_after", pk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
